// File: rtl/sdrc_app_burst_master.sv
// -----------------------------------------------------------------------------
// sdrc_app_burst_master
//   Command/stream front-end for the sdrc_core application port. One burst
//   command (addr, len, rd/wr) is accepted at a time. A write burst is staged
//   completely in an internal buffer before app_req is raised, so a word is
//   always available when the core pulses app_wr_next_req. A read burst
//   forwards app_rd_data to the user with one cycle of latency.
//
// Ports
//   clk_i, reset_i           single clock, synchronous active-high reset
//   cmd_*                    burst command (valid/ready)
//   wd_*                     write-data stream (valid/ready), byte enables active low
//   rd_data_o/rd_valid_o     read-data stream, no backpressure
//   cmd_done_o               one-cycle pulse at burst completion
//   busy_o                   not idle
//   err_stray_o              sticky, read data seen while no read burst is active
//   app_*                    sdrc_core application port
// -----------------------------------------------------------------------------
module sdrc_app_burst_master #(
   parameter int DW      = 32,
   parameter int AW      = 30,
   parameter int LW      = 9,
   parameter int WBUF_AW = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   // command port
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_wr_n_i,
   input  logic [AW-1:0]      cmd_addr_i,
   input  logic [LW-1:0]      cmd_len_i,
   // write-data stream
   input  logic               wd_valid_i,
   output logic               wd_ready_o,
   input  logic [DW-1:0]      wd_data_i,
   input  logic [DW/8-1:0]    wd_be_n_i,
   // read-data stream / status
   output logic [DW-1:0]      rd_data_o,
   output logic               rd_valid_o,
   output logic               cmd_done_o,
   output logic               busy_o,
   output logic               err_stray_o,
   // sdrc_core application port
   output logic               app_req_o,
   output logic [AW-1:0]      app_req_addr_o,
   output logic [LW-1:0]      app_req_len_o,
   output logic               app_req_wr_n_o,
   input  logic               app_req_ack_i,
   output logic [DW-1:0]      app_wr_data_o,
   output logic [DW/8-1:0]    app_wr_en_n_o,
   input  logic               app_wr_next_req_i,
   input  logic [DW-1:0]      app_rd_data_i,
   input  logic               app_rd_valid_i
);

   localparam int            BW      = DW / 8;
   localparam int            DEPTH   = 2 ** WBUF_AW;
   localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WFILL,
      S_REQ,
      S_WXFER,
      S_RXFER,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [LW-1:0] len;
      logic          wr_n;
   } cmd_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [BW-1:0] be_n;
   } wword_t;

   state_e               state_q, state_d;
   cmd_t                 cmd_q, cmd_d;
   logic [LW-1:0]        cnt_q, cnt_d;
   logic [WBUF_AW-1:0]   wptr_q, wptr_d;
   logic [WBUF_AW-1:0]   rptr_q, rptr_d;
   logic                 app_req_q, app_req_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 wd_ready_q, wd_ready_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [DW-1:0]        rd_data_q, rd_data_d;
   logic                 cmd_done_q, cmd_done_d;
   logic                 err_stray_q, err_stray_d;

   wword_t               wbuf_q [DEPTH];
   wword_t               rd_word;
   logic                 wbuf_we;

   logic [LW-1:0]        len_clamp;
   logic                 cmd_acc;
   logic                 wd_acc;
   logic                 last_beat;
   logic                 wr_present;

   assign len_clamp = (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;
   assign cmd_acc   = (state_q == S_IDLE)  && cmd_valid_i && cmd_ready_q;
   assign wd_acc    = (state_q == S_WFILL) && wd_valid_i  && wd_ready_q;
   // cnt_q counts completed beats of the current phase (fill, then transfer)
   assign last_beat = (cnt_q == cmd_q.len - LW'(1));
   assign rd_word   = wbuf_q[rptr_q];

   // -------------------------------------------------------------------------
   // Next-state / datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      err_stray_d = err_stray_q;
      wbuf_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_acc) begin
               cmd_d.addr = cmd_addr_i;
               cmd_d.len  = len_clamp;
               cmd_d.wr_n = cmd_wr_n_i;
               cnt_d      = '0;
               wptr_d     = '0;
               rptr_d     = '0;
               if (len_clamp == '0)  state_d = S_DONE;
               else if (!cmd_wr_n_i) state_d = S_WFILL;
               else                  state_d = S_REQ;
            end
         end

         S_WFILL: begin
            if (wd_acc) begin
               wbuf_we = 1'b1;
               // a full-depth burst wraps wptr back to 0; cnt_q still ends it
               wptr_d  = wptr_q + WBUF_AW'(1);
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = S_REQ;
               end else begin
                  cnt_d   = cnt_q + LW'(1);
               end
            end
         end

         S_REQ: begin
            if (app_req_ack_i)
               state_d = cmd_q.wr_n ? S_RXFER : S_WXFER;
         end

         S_WXFER: begin
            if (app_wr_next_req_i) begin
               rptr_d = rptr_q + WBUF_AW'(1);
               cnt_d  = cnt_q + LW'(1);
               if (last_beat) state_d = S_DONE;
            end
         end

         S_RXFER: begin
            if (app_rd_valid_i) begin
               rd_valid_d = 1'b1;
               rd_data_d  = app_rd_data_i;
               cnt_d      = cnt_q + LW'(1);
               if (last_beat) state_d = S_DONE;
            end
         end

         S_DONE:  state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase

      if (app_rd_valid_i && (state_q != S_RXFER))
         err_stray_d = 1'b1;

      // handshake outputs registered from the state we are about to enter
      app_req_d   = (state_d == S_REQ);
      cmd_ready_d = (state_d == S_IDLE);
      wd_ready_d  = (state_d == S_WFILL);
      cmd_done_d  = (state_q == S_DONE);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         cnt_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         app_req_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         wd_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         cmd_done_q  <= 1'b0;
         err_stray_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         app_req_q   <= app_req_d;
         cmd_ready_q <= cmd_ready_d;
         wd_ready_q  <= wd_ready_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         cmd_done_q  <= cmd_done_d;
         err_stray_q <= err_stray_d;
      end
   end

   // write buffer storage; contents need no reset
   always_ff @(posedge clk_i) begin
      if (wbuf_we) begin
         wbuf_q[wptr_q].data <= wd_data_i;
         wbuf_q[wptr_q].be_n <= wd_be_n_i;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // word 0 is already on the bus while the request is pending
   assign wr_present     = ((state_q == S_REQ) || (state_q == S_WXFER)) && !cmd_q.wr_n;

   assign app_wr_data_o  = wr_present ? rd_word.data : '0;
   assign app_wr_en_n_o  = wr_present ? rd_word.be_n : '1;

   assign app_req_o      = app_req_q;
   assign app_req_addr_o = cmd_q.addr;
   assign app_req_len_o  = cmd_q.len;
   assign app_req_wr_n_o = cmd_q.wr_n;

   assign cmd_ready_o    = cmd_ready_q;
   assign wd_ready_o     = wd_ready_q;
   assign rd_data_o      = rd_data_q;
   assign rd_valid_o     = rd_valid_q;
   assign cmd_done_o     = cmd_done_q;
   assign busy_o         = (state_q != S_IDLE);
   assign err_stray_o    = err_stray_q;

endmodule

// File: tb/tb_sdrc_app_burst_master.sv
// -----------------------------------------------------------------------------
// tb_sdrc_app_burst_master
//   Directed bench for sdrc_app_burst_master. The bench plays both the user
//   (command + write stream) and the sdrc_core (ack, next_req, read data).
// -----------------------------------------------------------------------------
module tb_sdrc_app_burst_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_wr_n;
   logic [29:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic [3:0]  wd_be_n;
   logic [31:0] rd_data;
   logic        rd_valid, cmd_done, busy, err_stray;
   logic        app_req, app_req_wr_n, app_req_ack, app_wr_next_req, app_rd_valid;
   logic [29:0] app_req_addr;
   logic [8:0]  app_req_len;
   logic [31:0] app_wr_data, app_rd_data;
   logic [3:0]  app_wr_en_n;

   int n_cmp = 0;
   int n_err = 0;
   int req_rise = 0;
   int done_cnt = 0;
   logic req_prev = 1'b0;

   logic [31:0] pat [256];
   logic [3:0]  pbe [256];
   logic [31:0] model [int];

   sdrc_app_burst_master dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .cmd_valid_i       (cmd_valid),
      .cmd_ready_o       (cmd_ready),
      .cmd_wr_n_i        (cmd_wr_n),
      .cmd_addr_i        (cmd_addr),
      .cmd_len_i         (cmd_len),
      .wd_valid_i        (wd_valid),
      .wd_ready_o        (wd_ready),
      .wd_data_i         (wd_data),
      .wd_be_n_i         (wd_be_n),
      .rd_data_o         (rd_data),
      .rd_valid_o        (rd_valid),
      .cmd_done_o        (cmd_done),
      .busy_o            (busy),
      .err_stray_o       (err_stray),
      .app_req_o         (app_req),
      .app_req_addr_o    (app_req_addr),
      .app_req_len_o     (app_req_len),
      .app_req_wr_n_o    (app_req_wr_n),
      .app_req_ack_i     (app_req_ack),
      .app_wr_data_o     (app_wr_data),
      .app_wr_en_n_o     (app_wr_en_n),
      .app_wr_next_req_i (app_wr_next_req),
      .app_rd_data_i     (app_rd_data),
      .app_rd_valid_i    (app_rd_valid)
   );

   always #5 clk = ~clk;

   // pulse monitors
   always @(posedge clk) begin
      if (app_req && !req_prev) req_rise++;
      req_prev <= app_req;
      if (cmd_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr_n, input logic [29:0] addr, input logic [8:0] len);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_wr_n  = wr_n;
      cmd_addr  = addr;
      cmd_len   = len;
      while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
      chk("cmd_ready_wait", 64'(n < 100), 1);
      tick();
      cmd_valid = 1'b0;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("busy_after_acc", busy, 1);
   endtask

   task automatic feed(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         wd_valid = 1'b1;
         wd_data  = pat[i];
         wd_be_n  = pbe[i];
         while (wd_ready !== 1'b1 && k < 100) begin tick(); k++; end
         if (k >= 100) chk("wd_ready_wait", 0, 1);
         tick();
         wd_valid = 1'b0;
         if (i < n - 1) begin
            chk("req_early", app_req, 0);
            for (int g = 0; g < gap; g++) begin
               tick();
               chk("req_gap", app_req, 0);
            end
         end else begin
            chk("req_after_fill", app_req, 1);
            chk("wd_ready_after_fill", wd_ready, 0);
         end
      end
   endtask

   task automatic wait_ack(input logic [29:0] addr, input logic [8:0] len,
                           input logic wr_n, input int dly);
      int k = 0;
      while (app_req !== 1'b1 && k < 300) begin tick(); k++; end
      chk("req_wait", 64'(k < 300), 1);
      chk("req_addr", app_req_addr, addr);
      chk("req_len", app_req_len, len);
      chk("req_wr_n", app_req_wr_n, wr_n);
      if (!wr_n) chk("wr_word0_in_req", app_wr_data, pat[0]);
      else       chk("rd_en_n_idle", app_wr_en_n, 4'hf);
      for (int d = 0; d < dly; d++) begin
         tick();
         chk("req_hold", app_req, 1);
         chk("req_addr_hold", app_req_addr, addr);
         chk("req_len_hold", app_req_len, len);
      end
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      chk("req_drop", app_req, 0);
   endtask

   task automatic finish_done();
      chk("done_not_yet", cmd_done, 0);
      tick();
      chk("done_pulse", cmd_done, 1);
      chk("busy_idle", busy, 0);
      tick();
      chk("done_once", cmd_done, 0);
   endtask

   task automatic core_wr(input int n, input logic [29:0] addr, input logic [8:0] len, input int dly);
      wait_ack(addr, len, 1'b0, dly);
      for (int i = 0; i < n; i++) begin
         chk("wr_data", app_wr_data, pat[i]);
         chk("wr_en_n", app_wr_en_n, pbe[i]);
         model[int'(addr) + i] = pat[i];
         app_wr_next_req = 1'b1;
         tick();
      end
      app_wr_next_req = 1'b0;
      chk("wr_en_n_after", app_wr_en_n, 4'hf);
      finish_done();
   endtask

   task automatic core_rd(input int n, input logic [29:0] addr, input logic [8:0] len, input int dly);
      wait_ack(addr, len, 1'b1, dly);
      for (int i = 0; i < n; i++) begin
         app_rd_valid = 1'b1;
         app_rd_data  = model[int'(addr) + i];
         tick();
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, pat[i]);
      end
      app_rd_valid = 1'b0;
      app_rd_data  = '0;
      chk("rd_last_done_not_yet", cmd_done, 0);
      tick();
      chk("rd_valid_end", rd_valid, 0);
      chk("rd_done_pulse", cmd_done, 1);
      tick();
      chk("rd_done_once", cmd_done, 0);
   endtask

   initial begin
      int r0, d0;
      reset = 1'b1;
      cmd_valid = 0; cmd_wr_n = 0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 0; wd_data = '0; wd_be_n = '1;
      app_req_ack = 0; app_wr_next_req = 0; app_rd_valid = 0; app_rd_data = '0;
      for (int i = 0; i < 256; i++) pbe[i] = 4'(i);
      pat[0] = 32'h11223344; pat[1] = 32'h22334455; pat[2] = 32'h33445566;
      pat[3] = 32'h44556677; pat[4] = 32'h55667788;

      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_app_req", app_req, 0);
      chk("rst_en_n", app_wr_en_n, 4'hf);
      chk("rst_wr_data", app_wr_data, 0);
      chk("rst_req_len", app_req_len, 0);
      chk("rst_err", err_stray, 0);
      chk("rst_wd_ready", wd_ready, 0);
      reset = 1'b0;
      tick();
      chk("idle_cmd_ready", cmd_ready, 1);

      // 1: write then read back, 5 words
      r0 = req_rise; d0 = done_cnt;
      send_cmd(1'b0, 30'h10000, 9'd5);
      feed(5, 0);
      core_wr(5, 30'h10000, 9'd5, 0);
      send_cmd(1'b1, 30'h10000, 9'd5);
      core_rd(5, 30'h10000, 9'd5, 0);
      chk("t1_req_pulses", 64'(req_rise - r0), 2);
      chk("t1_done_pulses", 64'(done_cnt - d0), 2);

      // 2: write with 3-cycle gaps on the write stream
      pat[0] = 32'hA1B2C3D4; pat[1] = 32'h0BADF00D; pat[2] = 32'hCAFEBABE;
      pat[3] = 32'h12345678; pat[4] = 32'h87654321;
      send_cmd(1'b0, 30'h20000, 9'd5);
      feed(5, 3);
      core_wr(5, 30'h20000, 9'd5, 0);

      // 3: read with a 7-cycle delayed ack
      send_cmd(1'b1, 30'h20000, 9'd5);
      core_rd(5, 30'h20000, 9'd5, 7);

      // 4a: zero length
      r0 = req_rise;
      send_cmd(1'b0, 30'h30000, 9'd0);
      chk("len0_req", app_req, 0);
      chk("len0_done_c1", cmd_done, 0);
      tick();
      chk("len0_done_c2", cmd_done, 1);
      tick();
      chk("len0_done_c3", cmd_done, 0);
      chk("len0_no_req", 64'(req_rise - r0), 0);

      // 4b: length 300 clamps to a full buffer
      for (int i = 0; i < 256; i++) pat[i] = {8'hC3, 8'(i), 8'(255 - i), 8'(i ^ 'h5A)};
      send_cmd(1'b0, 30'h200, 9'd300);
      feed(256, 0);
      core_wr(256, 30'h200, 9'd256, 0);
      send_cmd(1'b1, 30'h200, 9'd256);
      core_rd(256, 30'h200, 9'd256, 0);
      chk("no_stray_yet", err_stray, 0);

      // 5: reset mid-WXFER, then a clean write
      pat[0] = 32'hDEAD0000; pat[1] = 32'hDEAD0001; pat[2] = 32'hDEAD0002;
      pat[3] = 32'hDEAD0003; pat[4] = 32'hDEAD0004;
      send_cmd(1'b0, 30'h40000, 9'd5);
      feed(5, 0);
      wait_ack(30'h40000, 9'd5, 1'b0, 0);
      for (int i = 0; i < 2; i++) begin
         chk("t5_wr_data", app_wr_data, pat[i]);
         app_wr_next_req = 1'b1;
         tick();
      end
      app_wr_next_req = 1'b0;
      chk("t5_word2", app_wr_data, pat[2]);
      d0 = done_cnt;
      reset = 1'b1;
      tick();
      chk("t5_busy", busy, 0);
      chk("t5_app_req", app_req, 0);
      chk("t5_cmd_ready", cmd_ready, 0);
      chk("t5_wd_ready", wd_ready, 0);
      chk("t5_rd_valid", rd_valid, 0);
      chk("t5_cmd_done", cmd_done, 0);
      chk("t5_addr", app_req_addr, 0);
      chk("t5_len", app_req_len, 0);
      chk("t5_wr_n", app_req_wr_n, 0);
      chk("t5_wr_data0", app_wr_data, 0);
      chk("t5_en_n", app_wr_en_n, 4'hf);
      reset = 1'b0;
      repeat (3) tick();
      chk("t5_no_done", 64'(done_cnt - d0), 0);
      send_cmd(1'b0, 30'h40000, 9'd5);
      feed(5, 0);
      core_wr(5, 30'h40000, 9'd5, 0);

      // stray ack / next_req in IDLE are ignored
      app_req_ack = 1'b1; app_wr_next_req = 1'b1;
      tick();
      app_req_ack = 1'b0; app_wr_next_req = 1'b0;
      chk("stray_ack_busy", busy, 0);
      chk("stray_ack_req", app_req, 0);

      // 6: stray read data in IDLE
      app_rd_valid = 1'b1; app_rd_data = 32'hFFFF0000;
      tick();
      app_rd_valid = 1'b0;
      chk("t6_rd_valid", rd_valid, 0);
      chk("t6_err_set", err_stray, 1);
      repeat (3) tick();
      chk("t6_err_sticky", err_stray, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_err_clr", err_stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
